clock_reset_gen: RTL and testbench
==================================

// Module: clock_reset_gen
// PURPOSE
//   Top-level clock/reset generator for the SoC. Divides the board clock CLK by
//   2^DIV to produce the core clock clk. Converts the raw board reset RST into a
//   clean reset for the core logic.
//   Reset resetn, synchronous, active-low; clock clk (both are outputs of this block).
// PARAMETERS
//   DIV          1   clk = CLK / 2^DIV; 0 passes CLK through; legal range 0..30
//   RST_CYCLES   4   clk rising edges resetn stays low after RST releases; >=1
//   RST_ACT_HIGH 1   1: RST asserted high; 0: RST asserted low
// PORTS
//   CLK     in   1  board oscillator clock; every register in this block uses it
//   RST     in   1  raw board reset, asynchronous to CLK, polarity per RST_ACT_HIGH
//   clk     out  1  divided core clock, 50% duty cycle
//   resetn  out  1  core reset, active-low, changes only coincident with clk rising edges
// BEHAVIOUR
//   Divider
//   - div_cnt is a DIV-bit free-running up-counter on CLK.
//   - div_cnt is initialised to 0 and is NOT cleared by RST, so clk keeps running during reset.
//   - clk = div_cnt[DIV-1] for DIV>=1; clk = CLK for DIV=0.
//   - Wrap 2^DIV-1 -> 0 is natural modulo behaviour.
//   - clk_rise pulses for one CLK cycle on the CLK edge where clk goes 0->1,
//     i.e. when div_cnt == 2^(DIV-1)-1. For DIV=0, clk_rise is held at 1.
//   Reset input
//   - RST is normalised to active-high.
//   - It then passes through a 2-flop synchronizer on CLK, giving rst_s with 2 CLK cycles of latency.
//   - Any RST pulse of at least 2 CLK periods sets sticky rst_req in the CLK domain.
//   - rst_req clears on the first clk_rise where rst_s==0.
//   - Because of rst_req, a reset shorter than one clk period is never lost.
//   Reset stretch (register updates only when clk_rise==1)
//   - rst_cnt counts in clog2(RST_CYCLES+1) bits.
//   - rst_req==1: rst_cnt<=0 and resetn<=0.
//   - rst_req==0 and rst_cnt<RST_CYCLES: rst_cnt increments, and resetn stays 0.
//   - rst_cnt reaches RST_CYCLES: resetn<=1, and rst_cnt saturates there.
//   - resetn falls at the first clk rising edge after rst_s asserts.
//   - resetn rises exactly RST_CYCLES clk rising edges after the first clk rising edge that sees rst_req==0.
//   Power-up
//   - Initial values: div_cnt=0, sync flops=0, rst_req=1, rst_cnt=0, resetn=0.
//   - The core therefore gets a full reset pulse with no RST activity.
//   Boundary cases
//   - RST re-asserted during the stretch: counter restarts from 0, resetn stays 0.
//   - RST asserted while running: resetn drops at the next clk rise. clk itself is undisturbed.
//   - RST held forever: resetn held 0, clk still toggling.
//   - DIV=0: all clk_rise-gated logic updates every CLK edge.
//   - No combinational path from RST to any output.
// TESTING
//   - Divider, DIV=1, RST low from t=0: clk toggles every CLK rising edge (period 2 CLK).
//     Same with DIV=3: period 8 CLK, 4 high / 4 low.
//   - Power-up, DIV=1, RST_CYCLES=4, RST never asserted: resetn=0 at t=0,
//     rises 1 at clk rising edge #5 (1 clears rst_req, +4 stretch), then stays 1.
//   - Runtime reset, DIV=2: after resetn=1, pulse RST high for 2 CLK ->
//     resetn 0 at first clk rise after sync, returns 1 RST_CYCLES clk rises after release.
//   - Short pulse: DIV=3, RST high exactly 2 CLK mid clk-low phase -> still captured, resetn pulses low.
//   - Re-assert during stretch, RST_CYCLES=4: RST again after 2 counted edges ->
//     count restarts, resetn low total >=4 edges after final release.
//   - Polarity/pass-through: RST_ACT_HIGH=0, DIV=0: RST=0 holds resetn=0, clk==CLK;
//     RST=1 -> resetn=1 after 1+RST_CYCLES CLK edges past sync.

Source files
------------

// File: rtl/clock_reset_gen.sv
// Divides CLK by 2^DIV into clk and turns the raw board RST into resetn, held low RST_CYCLES clk rises after release.
// RST reaches resetn through a 2-flop synchronizer; resetn only changes on CLK edges where clk rises.
module clock_reset_gen #(
  parameter int DIV          = 1,
  parameter int RST_CYCLES   = 4,
  parameter bit RST_ACT_HIGH = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  output logic clk,
  output logic resetn
);

  localparam int CW = $clog2(RST_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(RST_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(RST_CYCLES - 1);

  logic clk_rise;

  generate
    if (DIV == 0) begin : g_pass
      assign clk      = CLK;
      assign clk_rise = 1'b1;
    end else begin : g_div
      localparam logic [DIV-1:0] RISE_AT = DIV'((64'd1 << (DIV - 1)) - 64'd1);

      // Power-up value only: the divider never stops, so clk runs through reset.
      logic [DIV-1:0] div_cnt = '0;

      always_ff @(posedge CLK) begin
        div_cnt <= div_cnt + DIV'(1);
      end

      assign clk      = div_cnt[DIV-1];
      assign clk_rise = (div_cnt == RISE_AT);
    end
  endgenerate

  logic rst_raw;
  logic rst_meta = 1'b0;
  logic rst_s    = 1'b0;
  logic rst_req  = 1'b1;
  logic req_eff;
  logic [CW-1:0] rst_cnt = '0;
  logic resetn_q = 1'b0;

  assign rst_raw = RST_ACT_HIGH ? RST : ~RST;

  // rst_req remembers a reset seen between clk rises so a short pulse is not lost.
  always_ff @(posedge CLK) begin
    rst_meta <= rst_raw;
    rst_s    <= rst_meta;
    rst_req  <= rst_s | (rst_req & ~clk_rise);
  end

  // rst_s is ORed in so resetn drops on the first clk rise after rst_s asserts.
  assign req_eff = rst_req | rst_s;

  always_ff @(posedge CLK) begin
    if (clk_rise) begin
      if (req_eff) begin
        rst_cnt  <= '0;
        resetn_q <= 1'b0;
      end else if (rst_cnt < CNT_MAX) begin
        rst_cnt  <= rst_cnt + CW'(1);
        resetn_q <= (rst_cnt == CNT_LAST);
      end else begin
        resetn_q <= 1'b1;
      end
    end
  end

  assign resetn = resetn_q;

endmodule

// File: tb/tb_clock_reset_gen.sv
// Four parameterisations of clock_reset_gen share one CLK and one reset stream, checked every CLK cycle
// against an edge-counting model of the divider and reset-stretch rules.
module tb_clock_reset_gen;

  localparam int NI = 4;

  logic CLK = 1'b0;
  logic rst = 1'b0;
  logic rst_pin_n;
  logic clk0, clk1, clk2, clk3;
  logic rn0, rn1, rn2, rn3;

  assign rst_pin_n = ~rst;

  clock_reset_gen #(.DIV(0), .RST_CYCLES(4), .RST_ACT_HIGH(1'b0)) u0 (
    .CLK(CLK), .RST(rst_pin_n), .clk(clk0), .resetn(rn0));
  clock_reset_gen #(.DIV(1), .RST_CYCLES(4), .RST_ACT_HIGH(1'b1)) u1 (
    .CLK(CLK), .RST(rst), .clk(clk1), .resetn(rn1));
  clock_reset_gen #(.DIV(2), .RST_CYCLES(1), .RST_ACT_HIGH(1'b1)) u2 (
    .CLK(CLK), .RST(rst), .clk(clk2), .resetn(rn2));
  clock_reset_gen #(.DIV(3), .RST_CYCLES(4), .RST_ACT_HIGH(1'b1)) u3 (
    .CLK(CLK), .RST(rst), .clk(clk3), .resetn(rn3));

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  int divs[NI] = '{0, 1, 2, 3};
  int rcs[NI]  = '{4, 4, 1, 4};
  bit raw[0:4095];
  bit pend[NI];
  int rcnt[NI];

  function automatic logic get_clk(input int i);
    case (i)
      0:       return clk0;
      1:       return clk1;
      2:       return clk2;
      default: return clk3;
    endcase
  endfunction

  function automatic logic get_rn(input int i);
    case (i)
      0:       return rn0;
      1:       return rn1;
      2:       return rn2;
      default: return rn3;
    endcase
  endfunction

  function automatic bit is_rise(input int d, input int e);
    if (d == 0) return 1'b1;
    return (e % (1 << d)) == (1 << (d - 1));
  endfunction

  function automatic bit exp_clk(input int d, input int e);
    if (d == 0) return 1'b1;
    return (e % (1 << d)) >= (1 << (d - 1));
  endfunction

  task automatic check(input string name, input int inst, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s u%0d edge %0d: got %0d want %0d", name, inst, n, act, expv);
    end
  endtask

  // One reset "event" is any edge whose synchronized RST is high; the clk rise that
  // follows it (and every rise while it is still high) restarts the stretch count.
  task automatic model_step(input int i);
    bit rs;
    rs = (n >= 3) ? raw[n - 2] : 1'b0;
    if (rs) pend[i] = 1'b1;
    if (is_rise(divs[i], n)) begin
      if (pend[i]) rcnt[i] = 0;
      else if (rcnt[i] < rcs[i]) rcnt[i]++;
      pend[i] = rs;
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      pend[i] = 1'b1;
      rcnt[i] = 0;
    end
    #2;
    for (int i = 0; i < NI; i++) begin
      check("init_resetn", i, get_rn(i), 0);
      check("init_clk", i, get_clk(i), 0);
    end
    forever begin
      @(posedge CLK);
      n++;
      raw[n] = rst;
      for (int i = 0; i < NI; i++) model_step(i);
      #2;
      for (int i = 0; i < NI; i++) begin
        check("clk", i, get_clk(i), exp_clk(divs[i], n));
        check("resetn", i, get_rn(i), (rcnt[i] >= rcs[i]) ? 1 : 0);
      end
      // Hand-derived anchors for power-up and the directed short pulse at edges 51..52.
      if (n == 3)  check("pin_clk3_e3", 3, clk3, 0);
      if (n == 4)  check("pin_clk3_e4", 3, clk3, 1);
      if (n == 8)  check("pin_clk3_e8", 3, clk3, 0);
      if (n == 4)  check("pin_pwrup_lo", 0, rn0, 0);
      if (n == 5)  check("pin_pwrup_hi", 0, rn0, 1);
      if (n == 8)  check("pin_pwrup_lo", 1, rn1, 0);
      if (n == 9)  check("pin_pwrup_hi", 1, rn1, 1);
      if (n == 5)  check("pin_pwrup_lo", 2, rn2, 0);
      if (n == 6)  check("pin_pwrup_hi", 2, rn2, 1);
      if (n == 35) check("pin_pwrup_lo", 3, rn3, 0);
      if (n == 36) check("pin_pwrup_hi", 3, rn3, 1);
      if (n == 53) check("pin_pulse_drop", 0, rn0, 0);
      if (n == 58) check("pin_pulse_stretch", 0, rn0, 0);
      if (n == 59) check("pin_pulse_release", 0, rn0, 1);
      if (n == 59) check("pin_short_before", 3, rn3, 1);
      if (n == 60) check("pin_short_drop", 3, rn3, 0);
      if (n == 91) check("pin_short_stretch", 3, rn3, 0);
      if (n == 92) check("pin_short_release", 3, rn3, 1);
      #5;
      check("clk_low_phase", 0, clk0, 0);
    end
  end

  task automatic at_edge(input int e);
    wait (n >= e);
    #4;
  endtask

  initial begin
    int cur;
    int len;
    rst = 1'b0;
    at_edge(50);
    rst = 1'b1;
    at_edge(52);
    rst = 1'b0;
    cur = 100;
    while (cur < 3000) begin
      at_edge(cur);
      rst = ~rst;
      if ($urandom_range(0, 3) == 0) len = $urandom_range(40, 250);
      else len = $urandom_range(1, 24);
      cur += len;
    end
    at_edge(3000);
    rst = 1'b0;
    at_edge(3300);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #80000;
    total++;
    bad++;
    $display("FAIL watchdog: got edge %0d want 3300", n);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
